// File: rtl/muldiv_pkg.sv
// Shared types and constants for the mul/div issue stage and its result selector.
package muldiv_pkg;

  typedef enum logic [2:0] {
    OpMul    = 3'b000,
    OpMulh   = 3'b001,
    OpMulhsu = 3'b010,
    OpMulhu  = 3'b011,
    OpDiv    = 3'b100,
    OpDivu   = 3'b101,
    OpRem    = 3'b110,
    OpRemu   = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    StIdle,
    StLaunch,
    StWait,
    StDone
  } state_e;

  localparam logic [31:0] QuotDivZero = 32'hFFFF_FFFF;
  localparam logic [31:0] SignedMin   = 32'h8000_0000;

  // Operand bit 32 follows the sign of the source only for signed operand positions.
  function automatic logic op_signed_a(op_e op);
    return (op == OpMul) || (op == OpMulh) || (op == OpMulhsu) || (op == OpDiv) || (op == OpRem);
  endfunction

  function automatic logic op_signed_b(op_e op);
    return (op == OpMul) || (op == OpMulh) || (op == OpDiv) || (op == OpRem);
  endfunction

endpackage

// File: rtl/muldiv_result_sel.sv
// Picks the architectural result from the core's halves, overriding divide-by-zero
// and signed-overflow cases that never reach the core.
module muldiv_result_sel
  import muldiv_pkg::*;
(
  input  op_e         op,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  input  logic [31:0] aval,
  input  logic [32:0] bval,
  output logic        special,
  output logic [31:0] result
);

  logic div_zero;
  logic overflow;

  always_comb begin
    div_zero = op[2] && (rs2 == '0);
    overflow = ((op == OpDiv) || (op == OpRem)) && (rs1 == SignedMin) && (rs2 == QuotDivZero);
    special  = div_zero || overflow;
    result   = '0;
    unique case (op)
      OpMul:                     result = bval[31:0];
      OpMulh, OpMulhsu, OpMulhu: result = {aval[30:0], bval[32]};
      OpDiv, OpDivu: begin
        if (div_zero)      result = QuotDivZero;
        else if (overflow) result = SignedMin;
        else               result = bval[31:0];
      end
      OpRem, OpRemu: begin
        if (div_zero)      result = rs1;
        else if (overflow) result = '0;
        else               result = aval;
      end
      default:           result = '0;
    endcase
  end

endmodule

// File: rtl/muldiv_issue.sv
// Issue stage for RV32M mul/div: latches operands, launches the shared 33-bit core
// and returns the selected result with a one-cycle done pulse.
module muldiv_issue
  import muldiv_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  funct3,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic        run,
  output logic        div,
  output logic [32:0] opa,
  output logic [32:0] opb,
  input  logic [32:0] aval,
  input  logic [32:0] bval,
  input  logic        ready
);

  state_e      state_q, state_d;
  op_e         op_q;
  logic [32:0] opa_q, opb_q;
  logic        div_q;
  logic [31:0] result_q, result_d;

  op_e         op_in;
  op_e         sel_op;
  logic [31:0] sel_rs1, sel_rs2;
  logic        special;
  logic [31:0] sel_result;
  logic        accept;
  logic        unused_aval;

  assign op_in       = op_e'(funct3);
  assign accept      = (state_q == StIdle) && start;
  assign unused_aval = aval[32];

  // In IDLE the live request feeds the selector so special cases finish on the start edge.
  assign sel_op  = (state_q == StIdle) ? op_in : op_q;
  assign sel_rs1 = (state_q == StIdle) ? rs1 : opa_q[31:0];
  assign sel_rs2 = (state_q == StIdle) ? rs2 : opb_q[31:0];

  muldiv_result_sel u_result_sel (
    .op      (sel_op),
    .rs1     (sel_rs1),
    .rs2     (sel_rs2),
    .aval    (aval[31:0]),
    .bval    (bval),
    .special (special),
    .result  (sel_result)
  );

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = special ? StDone : StLaunch;
          if (special) result_d = sel_result;
        end
      end
      StLaunch: state_d = StWait;
      StWait: begin
        if (ready) begin
          state_d  = StDone;
          result_d = sel_result;
        end
      end
      StDone:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      op_q     <= OpMul;
      opa_q    <= '0;
      opb_q    <= '0;
      div_q    <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      if (accept) begin
        op_q  <= op_in;
        opa_q <= {op_signed_a(op_in) & rs1[31], rs1};
        opb_q <= {op_signed_b(op_in) & rs2[31], rs2};
        div_q <= funct3[2];
      end
    end
  end

  assign busy   = (state_q != StIdle);
  assign done   = (state_q == StDone);
  assign run    = (state_q == StLaunch) || (state_q == StWait);
  assign result = result_q;
  assign div    = div_q;
  assign opa    = opa_q;
  assign opb    = opb_q;

endmodule

// File: tb/tb_muldiv_issue.sv
// Bench for muldiv_issue: behavioural 33-bit core plus an RV32M arithmetic reference.
module tb_muldiv_issue;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [31:0] rs1 = '0;
  logic [31:0] rs2 = '0;
  logic        busy, done, run, div;
  logic [31:0] result;
  logic [32:0] opa, opb;
  logic [32:0] aval = '0;
  logic [32:0] bval = '0;
  logic        core_ready = 1'b0;
  logic        stray_ready = 1'b0;
  logic        ready;

  int checks = 0;
  int errors = 0;
  int core_lat = 1;
  int core_cnt = 0;

  logic signed [32:0] csa, csb;
  logic signed [65:0] cpa, cpb, cpp;

  assign ready = core_ready | stray_ready;

  always #5 clk = ~clk;

  muldiv_issue dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .funct3 (funct3),
    .rs1    (rs1),
    .rs2    (rs2),
    .busy   (busy),
    .done   (done),
    .result (result),
    .run    (run),
    .div    (div),
    .opa    (opa),
    .opb    (opb),
    .aval   (aval),
    .bval   (bval),
    .ready  (ready)
  );

  // Downstream core: signed 33-bit arithmetic, answer after core_lat cycles of run.
  always @(negedge clk) begin
    if (!rst_n || !run) begin
      core_cnt   = 0;
      core_ready = 1'b0;
    end else begin
      core_cnt++;
      if (core_cnt >= core_lat && !core_ready) begin
        csa = $signed(opa);
        csb = $signed(opb);
        if (div) begin
          bval = csa / csb;
          aval = csa % csb;
        end else begin
          cpa  = csa;
          cpb  = csb;
          cpp  = cpa * cpb;
          aval = cpp[65:33];
          bval = cpp[32:0];
        end
        core_ready = 1'b1;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a,
                                            input logic [31:0] b);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint ua = longint'({32'b0, a});
    longint ub = longint'({32'b0, b});
    logic [63:0] p;
    bit ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'(sa / sb);
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : 32'(ua / ub);
      3'd6: return (b == 0) ? a : ovf ? 32'h0 : 32'(sa % sb);
      default: return (b == 0) ? a : 32'(ua % ub);
    endcase
  endfunction

  function automatic bit is_special(input logic [2:0] f, input logic [31:0] a,
                                    input logic [31:0] b);
    return f[2] && ((b == 0) || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  task automatic do_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] b, input int lat, input bit poke);
    logic [31:0] exp;
    logic [32:0] exp_opa, exp_opb;
    bit spec, got_done;
    int cyc, run_cnt, exp_lat;
    exp     = ref_model(f, a, b);
    spec    = is_special(f, a, b);
    exp_opa = {(f inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd6}) & a[31], a};
    exp_opb = {(f inside {3'd0, 3'd1, 3'd4, 3'd6}) & b[31], b};
    exp_lat = (lat > 2) ? lat + 1 : 3;
    core_lat = lat;
    @(negedge clk);
    funct3 = f; rs1 = a; rs2 = b; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0; funct3 = 3'($urandom); rs1 = $urandom; rs2 = $urandom;
    cyc = 0; run_cnt = 0; got_done = 1'b0;
    while (!got_done && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (run) run_cnt++;
      if (cyc == 1) begin
        check({tag, " busy"}, 64'(busy), 64'(1));
        check({tag, " opa"}, 64'(opa), 64'(exp_opa));
        check({tag, " opb"}, 64'(opb), 64'(exp_opb));
        check({tag, " div"}, 64'(div), 64'(f[2]));
      end
      if (poke && cyc == 2) begin
        start = 1'b1; rs1 = a ^ 32'h0000_1234; funct3 = f ^ 3'b010;
      end
      if (poke && cyc == 3) start = 1'b0;
      if (done) got_done = 1'b1;
    end
    start = 1'b0;
    check({tag, " done seen"}, 64'(got_done), 64'(1));
    check({tag, " result"}, 64'(result), 64'(exp));
    if (spec) begin
      check({tag, " latency"}, 64'(cyc), 64'(1));
      check({tag, " run cycles"}, 64'(run_cnt), 64'(0));
    end else begin
      check({tag, " latency"}, 64'(cyc), 64'(exp_lat));
      check({tag, " run cycles"}, 64'(run_cnt), 64'(exp_lat - 1));
    end
    @(negedge clk);
    check({tag, " done pulse"}, 64'(done), 64'(0));
    check({tag, " idle"}, 64'(busy), 64'(0));
    check({tag, " held"}, 64'(result), 64'(exp));
  endtask

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1);
  end

  initial begin
    bit saw_done;
    logic [2:0]  rf;
    logic [31:0] ra, rb;

    #1 rst_n = 1'b0;
    #1;
    check("reset busy", 64'(busy), 64'(0));
    check("reset done", 64'(done), 64'(0));
    check("reset run", 64'(run), 64'(0));
    check("reset div", 64'(div), 64'(0));
    check("reset opa", 64'(opa), 64'(0));
    check("reset opb", 64'(opb), 64'(0));
    check("reset result", 64'(result), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;

    do_op("div 7/2", 3'd4, 32'd7, 32'd2, 3, 1'b0);
    do_op("rem 7/2", 3'd6, 32'd7, 32'd2, 1, 1'b0);
    do_op("mulhu ones", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2, 1'b0);
    do_op("mulh ones", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4, 1'b0);
    do_op("mul ones", 3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 1'b0);
    do_op("divu by zero", 3'd5, 32'd5, 32'd0, 2, 1'b0);
    do_op("remu by zero", 3'd7, 32'd5, 32'd0, 2, 1'b0);
    do_op("div ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 2, 1'b0);
    do_op("rem ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 2, 1'b0);
    do_op("start in wait", 3'd4, 32'd7, 32'd2, 4, 1'b1);

    // Stray ready while idle must not launch or complete anything.
    stray_ready = 1'b1;
    saw_done = 1'b0;
    repeat (3) begin
      @(negedge clk);
      saw_done |= done | busy | run;
    end
    stray_ready = 1'b0;
    check("stray ready", 64'(saw_done), 64'(0));

    // Reset in WAIT drops run at once and the operation never completes.
    core_lat = 10;
    @(negedge clk);
    funct3 = 3'd4; rs1 = 32'd100; rs2 = 32'd7; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("run in wait", 64'(run), 64'(1));
    #2 rst_n = 1'b0;
    #1;
    check("reset drops run", 64'(run), 64'(0));
    check("reset drops busy", 64'(busy), 64'(0));
    check("reset clears result", 64'(result), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    saw_done = 1'b0;
    repeat (12) begin
      @(negedge clk);
      saw_done |= done | busy;
    end
    check("no done after reset", 64'(saw_done), 64'(0));

    for (int i = 0; i < 40; i++) begin
      rf = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 5))
        0: ra = 32'h0;
        1: ra = 32'h8000_0000;
        2: ra = 32'hFFFF_FFFF;
        default: ra = $urandom;
      endcase
      case ($urandom_range(0, 5))
        0: rb = 32'h0;
        1: rb = 32'hFFFF_FFFF;
        2: rb = 32'h8000_0000;
        default: rb = $urandom;
      endcase
      do_op($sformatf("rand%0d f%0d", i, rf), rf, ra, rb, $urandom_range(1, 4), 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
